// File: rtl/cu_defs.sv
// Shared definitions for the control_unit sequencer.
// States, ir field helpers, class opcodes, bus directions.
package cu_defs;

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_DEC,
    S_E0, S_E1, S_E2, S_E3,
    S_MOV, S_MOVI, S_IN, S_OUT,
    S_LD0, S_LD1, S_LD2,
    S_ST0, S_ST1, S_ST2,
    S_HLT, S_FLT
  } state_t;

  localparam int IR_ALU = 15;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_MOV   = 3'd1;
  localparam logic [2:0] C_MOVI  = 3'd2;
  localparam logic [2:0] C_LOAD  = 3'd3;
  localparam logic [2:0] C_STORE = 3'd4;
  localparam logic [2:0] C_IN    = 3'd5;
  localparam logic [2:0] C_OUT   = 3'd6;
  localparam logic [2:0] C_HALT  = 3'd7;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  function automatic logic [2:0] f_cls(input logic [15:0] v);
    return v[14:12];
  endfunction

  function automatic logic [1:0] f_rd(input logic [15:0] v);
    return v[11:10];
  endfunction

  function automatic logic [1:0] f_rs(input logic [15:0] v);
    return v[9:8];
  endfunction

  // Where each MFC wait state goes once the memory completes.
  function automatic state_t f_wait_next(input state_t s);
    state_t n;
    n = S_F0;
    if (s == S_F1)  n = S_F2;
    if (s == S_LD1) n = S_LD2;
    return n;
  endfunction

endpackage

// File: rtl/control_unit_reg_sel_dec.sv
// reg_sel_dec: 2-bit register select plus enable to one-hot.
// Used once for the Gx_in strobes and once for Gx_out.
module reg_sel_dec (
  input  logic [1:0] i_sel,
  input  logic       i_en,
  output logic [3:0] o_hot
);

  // Shift a single bit into place when enabled.
  always_comb begin
    o_hot = 4'b0000;
    if (i_en) o_hot = 4'b0001 << i_sel;
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired multi-cycle bus sequencer.
// Optional ALU-immediate operand: define CU_ALUI_EN.
module control_unit #(
  parameter int MFC_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        MFC,
  output logic        PC_Out,
  output logic        PC_inc,
  output logic        MAR_EN,
  output logic        MDR_EN_write,
  output logic        MDR_EN_read,
  output logic        MDR_out,
  output logic        IR_EN,
  output logic        mem_EN,
  output logic        mem_RW,
  output logic        ALUin1,
  output logic        ALUin2,
  output logic        ALU_outlach,
  output logic        ALU_outEN,
  output logic        G0_in,
  output logic        G1_in,
  output logic        G2_in,
  output logic        G3_in,
  output logic        G0_out,
  output logic        G1_out,
  output logic        G2_out,
  output logic        G3_out,
  output logic        P0_out,
  output logic        P1_in,
  output logic        immediate_out_Alui,
  output logic        immediate_out_Movi,
  output logic        halted,
  output logic        fault
);

  import cu_defs::*;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MFC_TIMEOUT - 1);

  state_t          r_state;
  logic [TO_W-1:0] r_cnt;

  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic       w_alui;
  logic       w_unused;
  logic [1:0] w_gin_sel;
  logic [1:0] w_gout_sel;
  logic       w_gin_en;
  logic       w_gout_en;
  logic [3:0] w_gin_hot;
  logic [3:0] w_gout_hot;

  assign w_rd     = f_rd(ir);
  assign w_rs     = f_rs(ir);
  assign w_unused = ^ir[7:0];

`ifdef CU_ALUI_EN
  assign w_alui = ir[7];
`else
  assign w_alui = 1'b0;
`endif

  // Register-file select for the state being decoded.
  always_comb begin
    w_gin_en   = 1'b0;
    w_gout_en  = 1'b0;
    w_gin_sel  = w_rd;
    w_gout_sel = w_rs;
    case (r_state)
      S_E0: begin
        w_gout_en  = 1'b1;
        w_gout_sel = w_rd;
      end
      S_E1: w_gout_en = !w_alui;
      S_E3, S_MOVI, S_IN, S_LD2: w_gin_en = 1'b1;
      S_MOV: begin
        w_gin_en  = 1'b1;
        w_gout_en = 1'b1;
      end
      S_OUT, S_LD0, S_ST1: w_gout_en = 1'b1;
      S_ST0: begin
        w_gout_en  = 1'b1;
        w_gout_sel = w_rd;
      end
      default: ;
    endcase
  end

  reg_sel_dec u_gin (
    .i_sel (w_gin_sel),
    .i_en  (w_gin_en),
    .o_hot (w_gin_hot)
  );

  reg_sel_dec u_gout (
    .i_sel (w_gout_sel),
    .i_en  (w_gout_en),
    .o_hot (w_gout_hot)
  );

  // Sequencer: next state plus registered strobes for the current state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state            <= S_F0;
      r_cnt              <= '0;
      PC_Out             <= 1'b0;
      PC_inc             <= 1'b0;
      MAR_EN             <= 1'b0;
      MDR_EN_write       <= 1'b0;
      MDR_EN_read        <= 1'b0;
      MDR_out            <= 1'b0;
      IR_EN              <= 1'b0;
      mem_EN             <= 1'b0;
      mem_RW             <= 1'b0;
      ALUin1             <= 1'b0;
      ALUin2             <= 1'b0;
      ALU_outlach        <= 1'b0;
      ALU_outEN          <= 1'b0;
      {G3_in, G2_in, G1_in, G0_in}     <= 4'b0;
      {G3_out, G2_out, G1_out, G0_out} <= 4'b0;
      P0_out             <= 1'b0;
      P1_in              <= 1'b0;
      immediate_out_Alui <= 1'b0;
      immediate_out_Movi <= 1'b0;
      halted             <= 1'b0;
      fault              <= 1'b0;
    end else begin
      PC_Out             <= 1'b0;
      PC_inc             <= 1'b0;
      MAR_EN             <= 1'b0;
      MDR_EN_write       <= 1'b0;
      MDR_EN_read        <= 1'b0;
      MDR_out            <= 1'b0;
      IR_EN              <= 1'b0;
      mem_EN             <= 1'b0;
      mem_RW             <= 1'b0;
      ALUin1             <= 1'b0;
      ALUin2             <= 1'b0;
      ALU_outlach        <= 1'b0;
      ALU_outEN          <= 1'b0;
      {G3_in, G2_in, G1_in, G0_in}     <= w_gin_hot;
      {G3_out, G2_out, G1_out, G0_out} <= w_gout_hot;
      P0_out             <= 1'b0;
      P1_in              <= 1'b0;
      immediate_out_Alui <= 1'b0;
      immediate_out_Movi <= 1'b0;
      halted             <= 1'b0;
      fault              <= 1'b0;
      unique case (r_state)
        S_F0: begin
          PC_Out  <= 1'b1;
          MAR_EN  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_F1;
        end
        S_F1, S_LD1, S_ST2: begin
          mem_EN <= 1'b1;
          mem_RW <= (r_state == S_ST2) ? MEM_WRITE : MEM_READ;
          if (MFC) begin
            MDR_EN_read <= (r_state != S_ST2);
            r_state     <= f_wait_next(r_state);
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == TO_LAST) r_state <= S_FLT;
          end
        end
        S_F2: begin
          MDR_out <= 1'b1;
          IR_EN   <= 1'b1;
          PC_inc  <= 1'b1;
          r_state <= S_DEC;
        end
        S_DEC: begin
          if (ir[IR_ALU]) begin
            r_state <= S_E0;
          end else begin
            unique case (f_cls(ir))
              C_NOP:   r_state <= S_F0;
              C_MOV:   r_state <= S_MOV;
              C_MOVI:  r_state <= S_MOVI;
              C_LOAD:  r_state <= S_LD0;
              C_STORE: r_state <= S_ST0;
              C_IN:    r_state <= S_IN;
              C_OUT:   r_state <= S_OUT;
              C_HALT:  r_state <= S_HLT;
            endcase
          end
        end
        S_E0: begin
          ALUin1  <= 1'b1;
          r_state <= S_E1;
        end
        S_E1: begin
          ALUin2             <= 1'b1;
          immediate_out_Alui <= w_alui;
          r_state            <= S_E2;
        end
        S_E2: begin
          ALU_outlach <= 1'b1;
          r_state     <= S_E3;
        end
        S_E3: begin
          ALU_outEN <= 1'b1;
          r_state   <= S_F0;
        end
        S_MOV: r_state <= S_F0;
        S_MOVI: begin
          immediate_out_Movi <= 1'b1;
          r_state            <= S_F0;
        end
        S_IN: begin
          P0_out  <= 1'b1;
          r_state <= S_F0;
        end
        S_OUT: begin
          P1_in   <= 1'b1;
          r_state <= S_F0;
        end
        S_LD0: begin
          MAR_EN  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_LD1;
        end
        S_LD2: begin
          MDR_out <= 1'b1;
          r_state <= S_F0;
        end
        S_ST0: begin
          MAR_EN  <= 1'b1;
          r_state <= S_ST1;
        end
        S_ST1: begin
          MDR_EN_write <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_ST2;
        end
        S_HLT: halted <= 1'b1;
        S_FLT: begin
          halted <= 1'b1;
          fault  <= 1'b1;
        end
        default: r_state <= S_F0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit.
// Expected strobe cycles are built from instruction rules.
module tb_control_unit;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MFC = 1'b0;
  logic [15:0] ir  = 16'h0000;

  logic PC_Out, PC_inc, MAR_EN, MDR_EN_write, MDR_EN_read;
  logic MDR_out, IR_EN, mem_EN, mem_RW;
  logic ALUin1, ALUin2, ALU_outlach, ALU_outEN;
  logic G0_in, G1_in, G2_in, G3_in;
  logic G0_out, G1_out, G2_out, G3_out;
  logic P0_out, P1_in, immediate_out_Alui, immediate_out_Movi;
  logic halted, fault;

  control_unit #(.MFC_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .ir(ir), .MFC(MFC),
    .PC_Out(PC_Out), .PC_inc(PC_inc), .MAR_EN(MAR_EN),
    .MDR_EN_write(MDR_EN_write), .MDR_EN_read(MDR_EN_read),
    .MDR_out(MDR_out), .IR_EN(IR_EN),
    .mem_EN(mem_EN), .mem_RW(mem_RW),
    .ALUin1(ALUin1), .ALUin2(ALUin2),
    .ALU_outlach(ALU_outlach), .ALU_outEN(ALU_outEN),
    .G0_in(G0_in), .G1_in(G1_in), .G2_in(G2_in), .G3_in(G3_in),
    .G0_out(G0_out), .G1_out(G1_out),
    .G2_out(G2_out), .G3_out(G3_out),
    .P0_out(P0_out), .P1_in(P1_in),
    .immediate_out_Alui(immediate_out_Alui),
    .immediate_out_Movi(immediate_out_Movi),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_out, pc_inc, mar_en, mdr_w, mdr_r, mdr_out, ir_en;
    logic mem_en, mem_rw;
    logic alu1, alu2, alul, aluo;
    logic [3:0] gin;
    logic [3:0] gout;
    logic p0, p1, ialu, imov, hlt, flt;
  } outs_t;

  typedef struct {
    outs_t       o;
    bit          mfc;
    bit          rst;
    logic [15:0] ir;
  } step_t;

  step_t       steps[$];
  outs_t       expq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] cur_ir = 16'h0000;
  outs_t       a_now;

  assign a_now = {PC_Out, PC_inc, MAR_EN, MDR_EN_write, MDR_EN_read,
                  MDR_out, IR_EN, mem_EN, mem_RW,
                  ALUin1, ALUin2, ALU_outlach, ALU_outEN,
                  G3_in, G2_in, G1_in, G0_in,
                  G3_out, G2_out, G1_out, G0_out,
                  P0_out, P1_in, immediate_out_Alui,
                  immediate_out_Movi, halted, fault};

  function automatic outs_t z();
    outs_t t;
    t = '0;
    return t;
  endfunction

  function automatic void add(outs_t o, bit m, bit r);
    step_t s;
    s.o   = o;
    s.mfc = m;
    s.rst = r;
    s.ir  = cur_ir;
    steps.push_back(s);
  endfunction

  // MFC is a don't-care for non-wait steps, so randomise it.
  function automatic void add_any(outs_t o);
    add(o, 1'($urandom_range(1, 0)), 1'b1);
  endfunction

  function automatic void do_reset();
    add(z(), 1'($urandom_range(1, 0)), 1'b0);
  endfunction

  // One memory access; w >= TO means MFC never comes.
  function automatic bit mem(bit rd, int w);
    outs_t o;
    o = z();
    o.mem_en = 1'b1;
    o.mem_rw = rd;
    if (w >= TO) begin
      repeat (TO) add(o, 1'b0, 1'b1);
      o = z();
      o.hlt = 1'b1;
      o.flt = 1'b1;
      repeat (4) add_any(o);
      do_reset();
      return 1'b1;
    end
    repeat (w) add(o, 1'b0, 1'b1);
    o.mdr_r = rd;
    add(o, 1'b1, 1'b1);
    return 1'b0;
  endfunction

  function automatic void instr(logic [15:0] v, int wf, int wx);
    outs_t      o;
    logic [1:0] rd;
    logic [1:0] rs;
    cur_ir = v;
    rd = v[11:10];
    rs = v[9:8];
    o = z();
    o.pc_out = 1'b1;
    o.mar_en = 1'b1;
    add_any(o);
    if (mem(1'b1, wf)) return;
    o = z();
    o.mdr_out = 1'b1;
    o.ir_en = 1'b1;
    o.pc_inc = 1'b1;
    add_any(o);
    add_any(z());
    if (v[15]) begin
      o = z(); o.gout[rd] = 1'b1; o.alu1 = 1'b1; add_any(o);
      o = z(); o.alu2 = 1'b1;
`ifdef CU_ALUI_EN
      if (v[7]) o.ialu = 1'b1;
      else o.gout[rs] = 1'b1;
`else
      o.gout[rs] = 1'b1;
`endif
      add_any(o);
      o = z(); o.alul = 1'b1; add_any(o);
      o = z(); o.aluo = 1'b1; o.gin[rd] = 1'b1; add_any(o);
      return;
    end
    o = z();
    case (v[14:12])
      3'd1: begin o.gout[rs] = 1'b1; o.gin[rd] = 1'b1; add_any(o); end
      3'd2: begin o.imov = 1'b1; o.gin[rd] = 1'b1; add_any(o); end
      3'd3: begin
        o.gout[rs] = 1'b1; o.mar_en = 1'b1; add_any(o);
        if (mem(1'b1, wx)) return;
        o = z(); o.mdr_out = 1'b1; o.gin[rd] = 1'b1; add_any(o);
      end
      3'd4: begin
        o.gout[rd] = 1'b1; o.mar_en = 1'b1; add_any(o);
        o = z(); o.gout[rs] = 1'b1; o.mdr_w = 1'b1; add_any(o);
        void'(mem(1'b0, wx));
      end
      3'd5: begin o.p0 = 1'b1; o.gin[rd] = 1'b1; add_any(o); end
      3'd6: begin o.gout[rs] = 1'b1; o.p1 = 1'b1; add_any(o); end
      3'd7: begin
        o.hlt = 1'b1;
        repeat (3) add_any(o);
        do_reset();
      end
      default: ;
    endcase
  endfunction

  // Reset arriving while a fetch is still waiting for MFC.
  function automatic void reset_mid(int w);
    outs_t o;
    cur_ir = 16'h0000;
    o = z();
    o.pc_out = 1'b1;
    o.mar_en = 1'b1;
    add_any(o);
    o = z();
    o.mem_en = 1'b1;
    o.mem_rw = 1'b1;
    repeat (w) add(o, 1'b0, 1'b1);
    do_reset();
  endfunction

  function automatic void build();
    do_reset();
    instr(16'h0000, 0, 0);
    instr(16'h0000, 0, 0);
    instr(16'h9600, 0, 0);
    instr(16'h3900, 0, 3);
    instr(16'h4600, 1, 2);
    instr(16'h9480, 0, 0);
    instr(16'h9400, 2, 0);
    instr(16'h1500, 0, 0);
    instr(16'h2A5C, 0, 0);
    instr(16'h5C00, 0, 0);
    instr(16'h6300, 0, 0);
    instr(16'h0000, TO, 0);
    instr(16'h9600, 0, 0);
    instr(16'h3900, 0, TO);
    instr(16'h7000, 0, 0);
    reset_mid(2);
    instr(16'h4600, 0, 0);
    for (int i = 0; i < 120; i++) begin
      instr(16'($urandom), $urandom_range(3, 0), $urandom_range(3, 0));
    end
    instr(16'h0000, 0, 0);
  endfunction

  // Monitor: compare each presented cycle with the next expected one.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      outs_t e;
      e = expq.pop_front();
      n_cmp++;
      if (a_now !== e) begin
        n_err++;
        $display("FAIL strobes t=%0t got %h want %h", $time, a_now, e);
      end
      n_cmp++;
      if ($countones({PC_Out, ALU_outEN, MDR_out, P0_out,
                      immediate_out_Alui, immediate_out_Movi,
                      G0_out, G1_out, G2_out, G3_out}) > 1) begin
        n_err++;
        $display("FAIL bus_onehot t=%0t got %h want <=1 driver", $time, a_now);
      end
    end
  end

  initial begin
    build();
    repeat (2) @(posedge clk);
    for (int k = 0; k < steps.size(); k++) begin
      #1;
      ir = steps[k].ir;
      expq.push_back(steps[k].o);
      if (k + 1 < steps.size()) begin
        MFC = steps[k + 1].mfc;
        rst = steps[k + 1].rst;
      end
      @(posedge clk);
    end
    #2;
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d left want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
